fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the pipelined CPU. It holds the PC, issues word requests to instruction memory, buffers returned instructions in order, and presents them to decode together with PC+8. It takes redirects from decode and execute: branches using the sign-extended, word-scaled immediate from the immediate-extend stage, and direct PC writes to R15. Each redirect flushes the buffered and in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch byte address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; responses in request order, latency ≥1 cycle
- imem_rdata  in  32  instruction word
- Instr  out  32  instruction to decode; bits [23:0] feed the immediate-extend stage
- instr_valid  out  1  Instr/PCPlus8 valid
- instr_ready  in  1  decode consumes the instruction
- PCPlus8  out  32  address of Instr + 8
- branch_taken  in  1  branch redirect request
- branch_base  in  32  PCPlus8 of the branch instruction
- ExtImm  in  32  extended branch offset from the immediate-extend stage
- pc_write  in  1  R15 written by execute
- pc_result  in  32  new PC value
- perf_fetched  out  32  instructions delivered (FETCH_PERF_EN)
- perf_flushed  out  32  responses/buffer entries discarded (FETCH_PERF_EN)

## Operation
- States: RESET → FETCH → (DRAIN ↔ FETCH).
  - RESET occupies one cycle after reset_n rises.
  - In FETCH, responses are written into the buffer.
  - DRAIN is entered on a redirect while responses are still outstanding.
- Request: imem_req = (state≠RESET) and (outstanding + buffered < 2). On imem_req & imem_ready:
  - the address and PC+8 are pushed to a 2-entry tag queue;
  - imem_addr += 4;
  - outstanding++.
- Response: imem_rvalid decrements outstanding.
  - Not stale: the word plus its tagged PC+8 enter a 2-entry FIFO.
  - Stale: stale_cnt-- and the response is discarded.
- The FIFO head drives Instr/PCPlus8/instr_valid. It pops on instr_valid & instr_ready.
- Redirect target:
  - pc_write wins over branch_taken: target = pc_result.
  - Otherwise target = branch_base + ExtImm, mod 2^32, with wrap-around allowed.
  - target[1:0] is forced to 00.
- On redirect:
  - FIFO and tag queue are cleared. Any pop that cycle is still honoured.
  - stale_cnt = outstanding, including a request accepted in the same cycle.
  - imem_addr = target on the next cycle.
  - The state moves to DRAIN if stale_cnt > 0.
- In DRAIN:
  - imem_req stays 0.
  - Return to FETCH when stale_cnt reaches 0.
  - A new redirect during DRAIN replaces the target. stale_cnt is unchanged.
- A push and a pop in the same cycle on a full FIFO is legal and keeps the count at 2.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, Instr=0, PCPlus8=RESET_PC+8
  - state=RESET, outstanding=0, stale_cnt=0
  - perf counters 0
- First imem_req occurs on the 2nd cycle after reset_n is sampled high.
- Latency from imem_rvalid to instr_valid is 1 cycle when the FIFO is empty. Ready/valid is standard: Instr is held stable while instr_valid & !instr_ready.
- Redirect to first request at the target:
  - 1 cycle if nothing is outstanding;
  - otherwise 1 cycle after the last stale response.
- reset_n low mid-operation returns every register to its reset value at the next edge. Responses arriving during or after reset that belong to pre-reset requests are ignored: after reset, outstanding=0 and any imem_rvalid with outstanding=0 is dropped.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetched increments on each FIFO pop;
  - perf_flushed increments per cleared FIFO entry on redirect and per dropped stale response;
  - both counters wrap.
- Not defined: the counters are not built, and perf_fetched/perf_flushed are tied to 32'h0.

## Structure
- fetch_pkg holds:
  - fetch_state_t enum (RESET, FETCH, DRAIN);
  - MAX_OUTSTANDING=2 and FIFO_DEPTH=2;
  - the fetch_entry_t struct {instr, pc_plus8}.
- One sub-module, fetch_buffer: 2-entry FIFO of fetch_entry_t with push, pop, clear, full, empty and count.
- PC, tag queue, redirect logic and FSM live in fetch_unit.

## Test plan
- Reset release with imem_ready=1 and 1-cycle rvalid returning 0xE3A00001 and 0xE2800002 → imem_addr 0x0 then 0x4. Instr 0xE3A00001 appears with PCPlus8 0x8, then 0xE2800002 with PCPlus8 0xC.
- Branch with branch_base=0x18 and ExtImm=0xFFFFFFF8 while 2 requests are outstanding → both responses dropped, perf_flushed=2, next imem_addr=0x10.
- instr_ready=0 for 5 cycles → FIFO holds 2, imem_req drops to 0 and Instr is held. Releasing instr_ready delivers 0x0, 0x4, 0x8 in order with no loss.
- pc_write with pc_result=0x102 and branch_taken in the same cycle → next imem_addr=0x100.
- Second redirect to 0x40 issued during DRAIN → no request until stale_cnt=0, then imem_addr=0x40.
- reset_n low for 1 cycle with 2 requests outstanding → all outputs return to reset values, and late imem_rvalid pulses produce no instr_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    RESET,
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam int MAX_OUTSTANDING = 2;
  localparam int FIFO_DEPTH      = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus8;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer between instruction memory and decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  localparam fetch_entry_t RESET_ENTRY = '{instr: 32'h0, pc_plus8: RESET_PC + 32'd8};

  fetch_entry_t mem_q [FIFO_DEPTH];
  fetch_entry_t mem_d [FIFO_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // A full buffer still accepts a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= RESET_ENTRY;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'(FIFO_DEPTH));
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request tagging, redirect/flush and delivery to decode.
// Optional FETCH_PERF_EN builds the perf_fetched/perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] PCPlus8,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] ExtImm,
  input  logic        pc_write,
  input  logic [31:0] pc_result,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
);

  fetch_state_t state_q, state_d;
  logic         boot_q, boot_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   stale_q, stale_d;
  logic [31:0]  tag_q [MAX_OUTSTANDING];
  logic [31:0]  tag_d [MAX_OUTSTANDING];
  logic         tag_rd_q, tag_rd_d;
  logic         tag_wr_q, tag_wr_d;

  logic         redirect, accept, resp, resp_stale, resp_live;
  logic [31:0]  target_raw, target;
  logic [2:0]   inflight;
  logic         fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [1:0]   fifo_count;
  fetch_entry_t push_entry, head_entry;

  fetch_buffer #(.RESET_PC(RESET_PC)) u_buffer (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .clear    (fifo_clear),
    .head     (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    redirect   = pc_write | branch_taken;
    target_raw = pc_write ? pc_result : (branch_base + ExtImm);
    target     = target_raw & 32'hFFFF_FFFC;
    // Requests are throttled so every in-flight word already has a buffer slot.
    inflight   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    imem_req   = (state_q == FETCH) && !fifo_full && (inflight < 3'(MAX_OUTSTANDING));
    accept     = imem_req && imem_ready;
    resp       = imem_rvalid && (outstanding_q != 2'd0);
    resp_stale = resp && (stale_q != 2'd0);
    resp_live  = resp && !resp_stale;

    fifo_pop   = instr_valid && instr_ready;
    fifo_push  = resp_live && !redirect;
    fifo_clear = redirect;
    push_entry.instr    = imem_rdata;
    push_entry.pc_plus8 = tag_q[tag_rd_q];

    state_d       = state_q;
    boot_d        = boot_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + 2'(accept) - 2'(resp);
    stale_d       = stale_q - 2'(resp_stale);
    tag_d         = tag_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;

    if (accept) begin
      pc_d            = pc_q + 32'd4;
      tag_d[tag_wr_q] = pc_q + 32'd8;
      tag_wr_d        = ~tag_wr_q;
    end
    if (resp_live) begin
      tag_rd_d = ~tag_rd_q;
    end
    // Everything still in flight after a redirect belongs to the old path.
    if (redirect) begin
      pc_d     = target;
      stale_d  = outstanding_d;
      tag_rd_d = 1'b0;
      tag_wr_d = 1'b0;
    end

    case (state_q)
      RESET: begin
        boot_d = 1'b0;
        if (!boot_q) state_d = FETCH;
      end
      FETCH, DRAIN: begin
        if (redirect) begin
          state_d = (outstanding_d != 2'd0) ? DRAIN : FETCH;
        end else if ((state_q == DRAIN) && (stale_d == 2'd0)) begin
          state_d = FETCH;
        end
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RESET;
      boot_q        <= 1'b1;
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      stale_q       <= 2'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= 32'h0;
      end
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_q        <= boot_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      tag_q         <= tag_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = !fifo_empty;
  assign Instr       = head_entry.instr;
  assign PCPlus8     = head_entry.pc_plus8;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // Flush count covers buffered entries lost to a redirect plus every discarded response.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fifo_pop);
    perf_flushed_d = perf_flushed_q + 32'(resp_stale);
    if (redirect) begin
      perf_flushed_d = perf_flushed_d + 32'(fifo_count) - 32'(fifo_pop) + 32'(resp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_fetched_q <= 32'h0;
      perf_flushed_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple in-order memory model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] Instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] PCPlus8;
   logic        branch_taken;
   logic [31:0] branch_base;
   logic [31:0] ExtImm;
   logic        pc_write;
   logic [31:0] pc_result;
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;

   int          checks = 0;
   int          errors = 0;
   logic        memHold = 1'b0;
   logic [31:0] pend[$];
   logic [63:0] got[$];

`ifdef FETCH_PERF_EN
   localparam logic [31:0] PERF_SCALE = 32'd1;
`else
   localparam logic [31:0] PERF_SCALE = 32'd0;
`endif

   fetch_unit dut (
      .clk         (clock),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .PCPlus8     (PCPlus8),
      .branch_taken(branch_taken),
      .branch_base (branch_base),
      .ExtImm      (ExtImm),
      .pc_write    (pc_write),
      .pc_result   (pc_result),
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed)
   );

   always #5 clock = ~clock;

   // Instruction memory contents: two known words at 0 and 4, an address pattern elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (addr == 32'h0) return 32'hE3A0_0001;
      if (addr == 32'h4) return 32'hE280_0002;
      return {8'hA5, addr[23:0]};
   endfunction

   // Memory answers each accepted request one cycle later, in order, unless held.
   always @(negedge clock) begin
      imem_rvalid = 1'b0;
      if (!memHold && pend.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memWord(pend.pop_front());
      end
      if (imem_req && imem_ready) pend.push_back(imem_addr);
   end

   // Record every instruction handed to decode.
   always @(negedge clock) begin
      if (instr_valid && instr_ready) got.push_back({Instr, PCPlus8});
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic bt, input logic [31:0] base, input logic [31:0] ext,
                                input logic pw, input logic [31:0] res);
      branch_taken = bt;
      branch_base  = base;
      ExtImm       = ext;
      pc_write     = pw;
      pc_result    = res;
      tick();
      branch_taken = 1'b0;
      pc_write     = 1'b0;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      memHold = 1'b0;
      tick();
      tick();
      pend.delete();
      got.delete();
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic waitReq(input string tag, input int limit);
      for (int i = 0; i < limit && !imem_req; i++) tick();
      checkOutput(tag, {63'h0, imem_req}, 64'h1);
   endtask

   task automatic waitGot(input string tag, input int n, input int limit);
      for (int i = 0; i < limit && got.size() < n; i++) tick();
      checkOutput(tag, {63'h0, got.size() >= n}, 64'h1);
   endtask

   function automatic logic [63:0] gotAt(input int i);
      if (got.size() > i) return got[i];
      return 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset_n      = 1'b0;
      imem_ready   = 1'b1;
      instr_ready  = 1'b1;
      branch_taken = 1'b0;
      branch_base  = 32'h0;
      ExtImm       = 32'h0;
      pc_write     = 1'b0;
      pc_result    = 32'h0;

      // Reset values and first two fetches
      repeat (3) tick();
      checkOutput("rst_req", {63'h0, imem_req}, 64'h0);
      checkOutput("rst_addr", {32'h0, imem_addr}, 64'h0);
      checkOutput("rst_valid", {63'h0, instr_valid}, 64'h0);
      checkOutput("rst_instr", {Instr, PCPlus8}, {32'h0, 32'h8});
      checkOutput("rst_perf", {perf_fetched, perf_flushed}, 64'h0);
      reset_n = 1'b1;
      tick();
      checkOutput("boot_req0", {63'h0, imem_req}, 64'h0);
      tick();
      checkOutput("boot_req1", {imem_req, imem_addr}, {32'h1, 32'h0});
      tick();
      checkOutput("addr_4", {imem_req, imem_addr}, {32'h1, 32'h4});
      tick();
      checkOutput("first_valid", {63'h0, instr_valid}, 64'h1);
      checkOutput("first_instr", {Instr, PCPlus8}, {32'hE3A0_0001, 32'h8});
      tick();
      checkOutput("second_instr", {Instr, PCPlus8}, {32'hE280_0002, 32'hC});

      // Branch with two requests outstanding
      doReset();
      memHold = 1'b1;
      repeat (6) tick();
      checkOutput("br_sat_req", {63'h0, imem_req}, 64'h0);
      applyStimulus(1'b1, 32'h18, 32'hFFFF_FFF8, 1'b0, 32'h0);
      checkOutput("br_drain", {imem_req, imem_addr}, {32'h0, 32'h10});
      memHold = 1'b0;
      waitReq("br_req_wait", 10);
      checkOutput("br_addr", {32'h0, imem_addr}, 64'h10);
      checkOutput("br_flushed", {32'h0, perf_flushed}, {32'h0, 32'd2 * PERF_SCALE});
      waitGot("br_got_wait", 1, 10);
      checkOutput("br_first", gotAt(0), {32'hA500_0010, 32'h18});

      // Decode backpressure fills the buffer and holds Instr
      instr_ready = 1'b0;
      doReset();
      for (int i = 0; i < 10 && !instr_valid; i++) tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_instr", {Instr, PCPlus8}, {32'hE3A0_0001, 32'h8});
         tick();
      end
      checkOutput("hold_req", {63'h0, imem_req}, 64'h0);
      instr_ready = 1'b1;
      waitGot("hold_got_wait", 3, 20);
      checkOutput("hold_got0", gotAt(0), {32'hE3A0_0001, 32'h8});
      checkOutput("hold_got1", gotAt(1), {32'hE280_0002, 32'hC});
      checkOutput("hold_got2", gotAt(2), {32'hA500_0008, 32'h10});
      checkOutput("hold_fetched", {32'h0, perf_fetched}, {32'h0, 32'd3 * PERF_SCALE});

      // pc_write beats a simultaneous branch, low bits forced to zero
      doReset();
      applyStimulus(1'b1, 32'h200, 32'h4, 1'b1, 32'h102);
      checkOutput("pw_addr_next", {32'h0, imem_addr}, 64'h100);
      waitReq("pw_req_wait", 10);
      checkOutput("pw_addr", {32'h0, imem_addr}, 64'h100);
      waitGot("pw_got_wait", 1, 10);
      checkOutput("pw_first", gotAt(0), {32'hA500_0100, 32'h108});
      checkOutput("pw_flushed", {32'h0, perf_flushed}, {32'h0, PERF_SCALE});

      // Second redirect while draining replaces the target
      doReset();
      memHold = 1'b1;
      repeat (6) tick();
      applyStimulus(1'b1, 32'h18, 32'h0, 1'b0, 32'h0);
      checkOutput("dr_addr1", {imem_req, imem_addr}, {32'h0, 32'h18});
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
      checkOutput("dr_addr2", {imem_req, imem_addr}, {32'h0, 32'h40});
      memHold = 1'b0;
      n = 0;
      while (!imem_req && n < 10) begin
         tick();
         n++;
      end
      checkOutput("dr_latency", 64'(n), 64'd2);
      checkOutput("dr_addr", {imem_req, imem_addr}, {32'h1, 32'h40});
      waitGot("dr_got_wait", 1, 10);
      checkOutput("dr_first", gotAt(0), {32'hA500_0040, 32'h48});

      // Reset mid-operation with two requests in flight
      doReset();
      memHold = 1'b1;
      repeat (6) tick();
      reset_n = 1'b0;
      tick();
      checkOutput("mid_rst_req", {imem_req, imem_addr}, {32'h0, 32'h0});
      checkOutput("mid_rst_instr", {Instr, PCPlus8}, {32'h0, 32'h8});
      checkOutput("mid_rst_valid", {63'h0, instr_valid}, 64'h0);
      reset_n = 1'b1;
      memHold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("late_drop", {63'h0, instr_valid}, 64'h0);
      end
      waitGot("late_got_wait", 1, 10);
      checkOutput("late_first", gotAt(0), {32'hE3A0_0001, 32'h8});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
